// File: rtl/csr_bus_arb.sv
// -----------------------------------------------------------------------------
// csr_bus_arb
//
// Two-master arbiter/sequencer in front of the single CSR slave.
// Master 0 is the CPU data port, master 1 the debug/DMA bridge.  Accesses are
// serialized one at a time with round-robin fairness: IDLE -> BUS -> ACK.
// A watchdog forces completion (with ERR_RDATA) of any access the slave does
// not acknowledge within TMO_CYC cycles in BUS.
//
// Handshake: a master raises mN_vld with stable we/addr/wdat and holds it
// until it sees its one-cycle mN_rdy pulse; mN_rdat is valid with that pulse
// and holds until the same master's next completion.  Master inputs are only
// sampled in IDLE.  The slave sees s_vld high for the whole BUS phase with
// s_we/s_addr/s_wdat constant, and completes with a one-cycle s_rdy, which is
// only honoured while s_vld is high.
//
// Optional build macro: CSR_ARB_STATS_EN -- enables the saturating 16-bit
// grant/timeout counters on stat_g0/stat_g1/stat_tmo.  Without it those
// outputs are constant zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m0_* / m1_*       master request (vld, we, addr, wdat) and response
//                     (rdat, rdy)
//   s_*               slave request (vld, we, addr, wdat) and response
//                     (rdat, rdy)
//   tmo_pulse         one-cycle pulse on a watchdog completion
//   stat_g0/g1/tmo    grant and timeout counters (optional feature)
//   dbg_state         current FSM state (0=IDLE, 1=BUS, 2=ACK)
// -----------------------------------------------------------------------------
module csr_bus_arb #(
   parameter int          AW        = 12,
   parameter int          TMO_CYC   = 64,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_vld,
   input  logic [3:0]    m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdat,
   output logic [31:0]   m0_rdat,
   output logic          m0_rdy,
   input  logic          m1_vld,
   input  logic [3:0]    m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdat,
   output logic [31:0]   m1_rdat,
   output logic          m1_rdy,
   output logic          s_vld,
   output logic [3:0]    s_we,
   output logic [AW-1:0] s_addr,
   output logic [31:0]   s_wdat,
   input  logic [31:0]   s_rdat,
   input  logic          s_rdy,
   output logic          tmo_pulse,
   output logic [15:0]   stat_g0,
   output logic [15:0]   stat_g1,
   output logic [15:0]   stat_tmo,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TMO_CYC - 1);

   state_t      state;
   state_t      state_nxt;
   logic        last_grant;  // master served by the most recent completion
   logic        winner;      // master owning the current access
   logic        pick;        // arbitration result, meaningful when any vld
   logic        any_req;
   logic        expire;
   logic [15:0] wdog;

   assign any_req = m0_vld | m1_vld;
   assign expire  = (wdog == WD_LAST);

   // Round robin: with both requesting, the master not served last wins.
   always_comb begin
      pick = 1'b0;
      if (m0_vld && m1_vld) begin
         pick = ~last_grant;
      end else if (m1_vld) begin
         pick = 1'b1;
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any_req) state_nxt = ST_BUS;
         ST_BUS:  if (s_rdy || expire) state_nxt = ST_ACK;
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      s_vld     = (state == ST_BUS);
      m0_rdy    = (state == ST_ACK) && !winner;
      m1_rdy    = (state == ST_ACK) &&  winner;
      dbg_state = state;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         winner     <= 1'b0;
         s_we       <= '0;
         s_addr     <= '0;
         s_wdat     <= '0;
         m0_rdat    <= '0;
         m1_rdat    <= '0;
         wdog       <= '0;
         tmo_pulse  <= 1'b0;
      end else begin
         tmo_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  winner <= pick;
                  s_we   <= pick ? m1_we   : m0_we;
                  s_addr <= pick ? m1_addr : m0_addr;
                  s_wdat <= pick ? m1_wdat : m0_wdat;
                  wdog   <= '0;
               end
            end
            ST_BUS: begin
               // A slave ack on the expiry cycle takes precedence.
               if (s_rdy) begin
                  if (winner) m1_rdat <= s_rdat;
                  else        m0_rdat <= s_rdat;
               end else if (expire) begin
                  if (winner) m1_rdat <= ERR_RDATA;
                  else        m0_rdat <= ERR_RDATA;
                  tmo_pulse <= 1'b1;
               end else begin
                  wdog <= wdog + 16'd1;
               end
            end
            ST_ACK: begin
               last_grant <= winner;
            end
            default: ;
         endcase
      end
   end

`ifdef CSR_ARB_STATS_EN
   logic grant_evt;
   assign grant_evt = (state == ST_IDLE) && any_req;

   // Saturating counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_g0  <= '0;
         stat_g1  <= '0;
         stat_tmo <= '0;
      end else begin
         if (grant_evt && !pick && (stat_g0 != 16'hFFFF))
            stat_g0 <= stat_g0 + 16'd1;
         if (grant_evt && pick && (stat_g1 != 16'hFFFF))
            stat_g1 <= stat_g1 + 16'd1;
         if (tmo_pulse && (stat_tmo != 16'hFFFF))
            stat_tmo <= stat_tmo + 16'd1;
      end
   end
`else
   assign stat_g0  = '0;
   assign stat_g1  = '0;
   assign stat_tmo = '0;
`endif

endmodule
